// File: rtl/mtimer_prescaled.sv
// RISC-V machine timer: 64-bit mtime advanced by a 16-bit prescaler, 64-bit mtimecmp, level interrupt.
// Latency: every request gets a registered response (rvalid/rdata/err) exactly one cycle later.
// Backpressure: none; requests are always accepted, back-to-back requests each get a response.
module mtimer_prescaled #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    timer_req_i,
  input  logic                    timer_we_i,
  input  logic [DataWidth/8-1:0]  timer_be_i,
  input  logic [AddressWidth-1:0] timer_addr_i,
  input  logic [DataWidth-1:0]    timer_wdata_i,
  output logic                    timer_rvalid_o,
  output logic [DataWidth-1:0]    timer_rdata_o,
  output logic                    timer_err_o,
  output logic                    timer_intr_o
);

  localparam logic [2:0] IdxMtimeLo = 3'd0;
  localparam logic [2:0] IdxMtimeHi = 3'd1;
  localparam logic [2:0] IdxCmpLo   = 3'd2;
  localparam logic [2:0] IdxCmpHi   = 3'd3;
  localparam logic [2:0] IdxCtrl    = 3'd4;
  localparam logic [2:0] IdxPresc   = 3'd5;
  localparam logic [2:0] IdxStatus  = 3'd6;

  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic [31:0] hi_shadow_q;
  logic [15:0] pcnt_q;
  logic [15:0] prescale_q;
  logic        en_q;
  logic        ie_q;

  logic [2:0]  reg_idx;
  logic        mapped;
  logic        wr_any;
  logic        rd_req;
  logic [31:0] wmask;
  logic [31:0] cur_word;
  logic [31:0] wr_word;
  logic [31:0] rd_word;
  logic        cmp_ge;
  logic        tick;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_ctrl;
  logic        wr_presc;
  logic        addr_unused;

  // Only the window offset is decoded; the base lives in the interconnect.
  assign addr_unused = ^{timer_addr_i[AddressWidth-1:12], timer_addr_i[1:0]};

  assign reg_idx = timer_addr_i[4:2];
  assign mapped  = (timer_addr_i[11:5] == 7'd0) && (reg_idx != 3'd7);
  // A write with no byte lanes set is a legal no-op, so it must not disturb pcnt or drop a tick.
  assign wr_any  = timer_req_i && timer_we_i && mapped && (timer_be_i != '0);
  assign rd_req  = timer_req_i && !timer_we_i;
  assign wmask   = {{8{timer_be_i[3]}}, {8{timer_be_i[2]}}, {8{timer_be_i[1]}}, {8{timer_be_i[0]}}};

  assign wr_mtime_lo = wr_any && (reg_idx == IdxMtimeLo);
  assign wr_mtime_hi = wr_any && (reg_idx == IdxMtimeHi);
  assign wr_cmp_lo   = wr_any && (reg_idx == IdxCmpLo);
  assign wr_cmp_hi   = wr_any && (reg_idx == IdxCmpHi);
  assign wr_ctrl     = wr_any && (reg_idx == IdxCtrl);
  assign wr_presc    = wr_any && (reg_idx == IdxPresc);

  assign cmp_ge = (mtime_q >= mtimecmp_q);
  assign tick   = en_q && (pcnt_q == prescale_q);

  // Live value of the addressed register, used as the base for byte-lane merging on writes.
  always_comb begin
    cur_word = 32'd0;
    case (reg_idx)
      IdxMtimeLo: cur_word = mtime_q[31:0];
      IdxMtimeHi: cur_word = mtime_q[63:32];
      IdxCmpLo:   cur_word = mtimecmp_q[31:0];
      IdxCmpHi:   cur_word = mtimecmp_q[63:32];
      IdxCtrl:    cur_word = {30'd0, ie_q, en_q};
      IdxPresc:   cur_word = {16'd0, prescale_q};
      default:    cur_word = 32'd0;
    endcase
  end

  assign wr_word = (cur_word & ~wmask) | (timer_wdata_i & wmask);

  // Read mux: MTIME_HI returns the shadow captured by the last MTIME_LO read.
  always_comb begin
    rd_word = 32'd0;
    if (mapped) begin
      case (reg_idx)
        IdxMtimeHi: rd_word = hi_shadow_q;
        IdxStatus:  rd_word = {31'd0, cmp_ge};
        default:    rd_word = cur_word;
      endcase
    end
  end

  // Prescaler: any CTRL/PRESCALE write restarts the period; an mtime write does not touch it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= 16'd0;
    end else if (wr_ctrl || wr_presc) begin
      pcnt_q <= 16'd0;
    end else if (en_q) begin
      pcnt_q <= tick ? 16'd0 : pcnt_q + 16'd1;
    end
  end

  // mtime: a bus write to either half overrides the whole register and swallows a coincident tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q <= 64'd0;
    end else if (wr_mtime_lo) begin
      mtime_q <= {mtime_q[63:32], wr_word};
    end else if (wr_mtime_hi) begin
      mtime_q <= {wr_word, mtime_q[31:0]};
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  // Software-visible configuration registers, merged per byte lane.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtimecmp_q <= '1;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      prescale_q <= 16'd0;
    end else begin
      if (wr_cmp_lo) mtimecmp_q[31:0]  <= wr_word;
      if (wr_cmp_hi) mtimecmp_q[63:32] <= wr_word;
      if (wr_ctrl) begin
        en_q <= wr_word[0];
        ie_q <= wr_word[1];
      end
      if (wr_presc) prescale_q <= wr_word[15:0];
    end
  end

  // Registered bus response and the hi-half shadow, both sampled at the request edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_rvalid_o <= 1'b0;
      timer_rdata_o  <= 32'd0;
      timer_err_o    <= 1'b0;
      hi_shadow_q    <= 32'd0;
    end else begin
      timer_rvalid_o <= timer_req_i;
      timer_err_o    <= timer_req_i && !mapped;
      timer_rdata_o  <= rd_req ? rd_word : 32'd0;
      if (rd_req && mapped && (reg_idx == IdxMtimeLo)) hi_shadow_q <= mtime_q[63:32];
    end
  end

  // Level interrupt registered from the current register values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_intr_o <= 1'b0;
    end else begin
      timer_intr_o <= ie_q && cmp_ge;
    end
  end

endmodule

// File: doc/mtimer_prescaled.md
# mtimer_prescaled

Memory-mapped RISC-V machine timer. It is a bus device in the `Timer` slot (base 0x8000_2000, 4 KiB window) and produces the level interrupt `timer_intr_o`, which drives the core's `i_timer_interrupt` input. It provides a 64-bit `mtime` counter that advances once per programmable prescaler period, and a 64-bit `mtimecmp` compare register. It also provides a read-consistency shadow for the upper half of `mtime`.

## Interface
Parameters:
- `DataWidth`, 32: bus data width; only 32 is supported.
- `AddressWidth`, 32: bus address width.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset; one clock, reset is asynchronous and active-low.
- `timer_req_i`  in  1  single-cycle access request; no grant, always accepted.
- `timer_we_i`  in  1  1 = write, 0 = read.
- `timer_be_i`  in  4  byte enables for writes; ignored on reads.
- `timer_addr_i`  in  32  byte address; decoded on bits [4:2].
- `timer_wdata_i`  in  32  write data.
- `timer_rvalid_o`  out  1  response strobe for every request, reads and writes.
- `timer_rdata_o`  out  32  read data, valid while `timer_rvalid_o` = 1.
- `timer_err_o`  out  1  error for an unmapped offset, qualified by `timer_rvalid_o`.
- `timer_intr_o`  out  1  registered level interrupt.

## Operation
Register map (offset within window):
- 0x00 `MTIME_LO` (RW): `mtime[31:0]`. A read also latches `mtime[63:32]` into `hi_shadow`.
- 0x04 `MTIME_HI` (RW): a read returns `hi_shadow`; a write updates `mtime[63:32]`.
- 0x08 `MTIMECMP_LO` (RW): `mtimecmp[31:0]`.
- 0x0C `MTIMECMP_HI` (RW): `mtimecmp[63:32]`.
- 0x10 `CTRL` (RW): bit0 `en` (count enable), bit1 `ie` (interrupt enable); bits [31:2] read 0.
- 0x14 `PRESCALE` (RW): bits [15:0]; bits [31:16] read 0 and ignore writes.
- 0x18 `STATUS` (RO): bit0 = `mtime >= mtimecmp` (unsigned 64-bit compare); writes are ignored with no error.
- 0x1C, and any address with bits [11:5] ≠ 0: unmapped. Read returns 0 with `err` = 1; write has no effect and returns `err` = 1.

Writes apply per byte lane under `timer_be_i`. `be` = 0 is a legal no-op write and gives no error.

Prescaler:
- 16-bit `pcnt`, runs only while `en` = 1.
- When `pcnt == PRESCALE`: `pcnt` ← 0 and a tick fires. Otherwise `pcnt` ← `pcnt` + 1.
- `PRESCALE` = 0 gives a tick every cycle. `PRESCALE` = N gives a tick every N+1 cycles.
- `en` = 0 freezes `pcnt` and `mtime`.
- Writing `PRESCALE` or `CTRL` clears `pcnt` to 0.

`mtime`:
- A tick increments it by 1 as a full 64-bit increment with carry into the upper word.
- 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- A bus write to `MTIME_LO` or `MTIME_HI` in the same cycle as a tick: the written value wins for the whole 64-bit register, the tick is dropped, and `pcnt` is unaffected.

Interrupt:
- `timer_intr_o` ← `ie & (mtime >= mtimecmp)`, registered from the current-cycle register values.
- No clear operation exists. Software deasserts the interrupt by raising `mtimecmp` or clearing `ie`.

## Timing
- Reset values:
  - `mtime`, `pcnt`, `hi_shadow`, `CTRL`, `PRESCALE` = 0.
  - `mtimecmp` = all ones.
  - `timer_rvalid_o`, `timer_err_o`, `timer_intr_o` = 0.
  - `timer_rdata_o` = 0.
- Access latency:
  - `timer_rvalid_o` is asserted exactly one cycle after `timer_req_i`, for one cycle per request.
  - Back-to-back requests on consecutive cycles each get a response.
  - `timer_rdata_o` is registered and reflects register state at the request edge. A read of `MTIME_LO` returns the pre-tick value if a tick occurs on that edge.
  - `hi_shadow` captures `mtime[63:32]` on the same edge.
- Write visibility: a write takes effect at the request edge. A read issued the next cycle returns the new value.
- Interrupt latency:
  - `timer_intr_o` rises one cycle after the register update that makes the compare true (`mtime` tick, `mtimecmp` write, or `ie` set).
  - It falls one cycle after the update that makes the compare false.
- Reset asserted mid-operation clears all state immediately. Any outstanding response is lost: `rvalid` = 0.

## Test plan
- **Reset and idle:** after reset, read `MTIMECMP_LO` → `rdata` 0xFFFF_FFFF with `rvalid` one cycle after `req`. `timer_intr_o` stays 0 with `en` = 0.
- **Prescale:** `PRESCALE` = 3, `CTRL` = 1. After 40 cycles, read `MTIME_LO` → 10 (±1 depending on the sampling edge). `PRESCALE` = 0 → +1 per cycle.
- **Carry and shadow:** write `MTIME_LO` = 0xFFFF_FFFE, `MTIME_HI` = 5, `PRESCALE` = 0, `en` = 1. Read `MTIME_LO` after the wrap, then `MTIME_HI` → 6. `MTIME_HI` must equal the value latched at the `LO` read even if further ticks occur.
- **Interrupt:** `mtimecmp` = 20, `mtime` = 0, `PRESCALE` = 0, `CTRL` = 3. `timer_intr_o` rises one cycle after `mtime` reaches 20. Writing `MTIMECMP_LO` = 0xFFFF_FFFF → the interrupt falls one cycle later.
- **Byte enables and errors:**
  - Write `MTIMECMP_LO` = 0xAABBCCDD with `be` = 0b0101 over 0xFFFF_FFFF → read 0xFFBBFFDD.
  - Read 0x1C → `err` = 1, `rdata` = 0.
  - Write 0x40 → `err` = 1, no state change.
- **Collision:** force a tick and an `MTIME_LO` write of 0x100 on the same edge → read returns 0x100 (or 0x101 if a later tick landed), never the ticked old value.
